// File: rtl/bit_deinterleaver.sv
// rtl/bit_deinterleaver.sv - block bit deinterleaver with a two-bank ping-pong RAM
//
// Purpose
//   Sits directly after the soft/hard demodulator. Each block of N_ROW*N_COL
//   input bits is written row-wise into one RAM bank. The bank is then read
//   back column-wise, which restores the pre-interleave bit order for the
//   channel decoder. While one bank is being read, the other bank can be filled.
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst      in   1   asynchronous reset, active low
//   di       in   1   demodulated input bit
//   di_vld   in   1   di qualifier; gaps allowed anywhere
//   do_bit   out  1   deinterleaved output bit
//   do_vld   out  1   do_bit qualifier
//   do_sof   out  1   pulse with the first bit of each output block
//   do_eof   out  1   pulse with the last bit of each output block
//   blk_cnt  out  16  count of completed output blocks (BIT_DEINTLV_BLKCNT_EN only)
//
// Configuration
//   BIT_DEINTLV_BLKCNT_EN  when defined, adds the blk_cnt port and its counter

module bit_deinterleaver #(
   parameter int N_ROW = 16,
   parameter int N_COL = 64,
   parameter int AW    = $clog2(N_ROW * N_COL)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        di,
   input  logic        di_vld,
   output logic        do_bit,
   output logic        do_vld,
   output logic        do_sof,
   output logic        do_eof
`ifdef BIT_DEINTLV_BLKCNT_EN
   ,
   output logic [15:0] blk_cnt
`endif
);

   localparam int N  = N_ROW * N_COL;
   localparam int RW = $clog2(N_ROW);
   localparam int CW = $clog2(N_COL);

   typedef enum logic {
      S_IDLE,
      S_READ
   } state_t;

   // Two banks of N bits, addressed as {bank, offset}. Contents survive reset.
   logic mem [0:2*N-1];

   logic [AW-1:0] wr_cnt;
   logic          wr_bank;
   logic          wr_last;
   logic [1:0]    full;

   state_t        state;
   state_t        state_nxt;
   logic [RW-1:0] row_cnt;
   logic [CW-1:0] col_cnt;
   logic          rd_bank;
   logic          rd_en;
   logic          rd_first;
   logic          rd_last;
   logic [AW-1:0] rd_addr;

   // ------------------------------------------------------------------
   // Write side: linear row-major fill of the current write bank
   // ------------------------------------------------------------------
   assign wr_last = di_vld && (wr_cnt == AW'(N - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
      end else if (di_vld) begin
         if (wr_last) begin
            wr_cnt  <= '0;
            wr_bank <= ~wr_bank;
         end else begin
            wr_cnt <= wr_cnt + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (di_vld) begin
         mem[{wr_bank, wr_cnt}] <= di;
      end
   end

   // Reader clears its bank and writer sets its bank in the same cycle
   // without interfering; the two always refer to different banks in
   // legal operation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full <= 2'b00;
      end else begin
         if (rd_last) begin
            full[rd_bank] <= 1'b0;
         end
         if (wr_last) begin
            full[wr_bank] <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read side FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      rd_last   = 1'b0;
      case (state)
         S_IDLE: begin
            if (full[rd_bank]) begin
               state_nxt = S_READ;
            end
         end
         S_READ: begin
            rd_en = 1'b1;
            if ((row_cnt == RW'(N_ROW - 1)) && (col_cnt == CW'(N_COL - 1))) begin
               rd_last = 1'b1;
               // Continue straight into the other bank when it is already
               // complete so back-to-back blocks leave no bubble.
               if (!full[~rd_bank]) begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign rd_first = (row_cnt == '0) && (col_cnt == '0);

   // Row is the fast counter, column the slow one: output index j reads
   // address (j % N_ROW) * N_COL + j / N_ROW without any divider.
   assign rd_addr = AW'(row_cnt) * AW'(N_COL) + AW'(col_cnt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_cnt <= '0;
         col_cnt <= '0;
         rd_bank <= 1'b0;
      end else if (rd_en) begin
         if (row_cnt == RW'(N_ROW - 1)) begin
            row_cnt <= '0;
            if (col_cnt == CW'(N_COL - 1)) begin
               col_cnt <= '0;
               rd_bank <= ~rd_bank;
            end else begin
               col_cnt <= col_cnt + CW'(1);
            end
         end else begin
            row_cnt <= row_cnt + RW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Registered RAM read and output flags, one cycle after address issue
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         do_bit <= 1'b0;
         do_vld <= 1'b0;
         do_sof <= 1'b0;
         do_eof <= 1'b0;
      end else begin
         do_bit <= rd_en ? mem[{rd_bank, rd_addr}] : 1'b0;
         do_vld <= rd_en;
         do_sof <= rd_en && rd_first;
         do_eof <= rd_last;
      end
   end

`ifdef BIT_DEINTLV_BLKCNT_EN
   // Advances on the same edge that raises do_eof; wraps naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blk_cnt <= 16'd0;
      end else if (rd_last) begin
         blk_cnt <= blk_cnt + 16'd1;
      end
   end
`endif

endmodule
